// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: two single-beat requesters share one BRAM port through a round-robin
// arbiter with a registered issue stage. Optional `BRAM_ARB_LOCK_EN adds s0_lock/s1_lock.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  localparam int STROBE_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s0_valid,
  output logic                    s0_ready,
  input  logic [ADDR_WIDTH-1:0]   s0_addr,
  input  logic [DATA_WIDTH-1:0]   s0_wdata,
  input  logic [STROBE_WIDTH-1:0] s0_we,
  output logic                    s0_rvalid,
  output logic [DATA_WIDTH-1:0]   s0_rdata,
  input  logic                    s1_valid,
  output logic                    s1_ready,
  input  logic [ADDR_WIDTH-1:0]   s1_addr,
  input  logic [DATA_WIDTH-1:0]   s1_wdata,
  input  logic [STROBE_WIDTH-1:0] s1_we,
  output logic                    s1_rvalid,
  output logic [DATA_WIDTH-1:0]   s1_rdata,
`ifdef BRAM_ARB_LOCK_EN
  input  logic                    s0_lock,
  input  logic                    s1_lock,
`endif
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_din,
  input  logic [DATA_WIDTH-1:0]   m_dout,
  output logic                    m_en,
  output logic [STROBE_WIDTH-1:0] m_we
);

  logic rr;
  logic gnt0, gnt1, hs_any, rr_upd;
  logic iss_rd, iss_id;
  logic [READ_LATENCY-1:0] pipe_rd, pipe_id;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

`ifdef BRAM_ARB_LOCK_EN
  logic locked, owner, owner_valid, owner_lock, hs_lock;
  assign owner_valid = owner ? s1_valid : s0_valid;
  assign owner_lock  = owner ? s1_lock : s0_lock;
  assign hs_lock     = s1_ready ? s1_lock : s0_lock;
`endif

  always_comb begin
    gnt0 = s0_valid && !(s1_valid && rr);
    gnt1 = s1_valid && !(s0_valid && !rr);
`ifdef BRAM_ARB_LOCK_EN
    // a held lock shuts the non-owner out entirely
    if (locked) begin
      gnt0 = s0_valid && !owner;
      gnt1 = s1_valid && owner;
    end
`endif
  end

  assign s0_ready = gnt0 && !rst;
  assign s1_ready = gnt1 && !rst;
  assign hs_any   = s0_ready || s1_ready;

`ifdef BRAM_ARB_LOCK_EN
  assign rr_upd = hs_any && !(locked && hs_lock);
`else
  assign rr_upd = hs_any;
`endif

  always_ff @(posedge clk) begin
    if (rst) rr <= 1'b0;
    else if (rr_upd) rr <= s0_ready;
  end

`ifdef BRAM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= 1'b0;
      owner  <= 1'b0;
    end else if (hs_any) begin
      owner  <= s1_ready;
      locked <= hs_lock;
    end else if (locked && !owner_valid && !owner_lock) begin
      locked <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      m_en   <= 1'b0;
      m_we   <= '0;
      m_addr <= '0;
      m_din  <= '0;
      iss_rd <= 1'b0;
      iss_id <= 1'b0;
    end else begin
      m_en   <= hs_any;
      iss_id <= s1_ready;
      if (s1_ready) begin
        m_addr <= s1_addr;
        m_din  <= s1_wdata;
        m_we   <= s1_we;
        iss_rd <= (s1_we == '0);
      end else if (s0_ready) begin
        m_addr <= s0_addr;
        m_din  <= s0_wdata;
        m_we   <= s0_we;
        iss_rd <= (s0_we == '0);
      end else begin
        m_we   <= '0;
        iss_rd <= 1'b0;
      end
    end
  end

  // bit 0 is the youngest issue; the top bit lines up with RAM dout
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_rd <= '0;
      pipe_id <= '0;
    end else begin
      pipe_rd <= (pipe_rd << 1) | READ_LATENCY'(iss_rd);
      pipe_id <= (pipe_id << 1) | READ_LATENCY'(iss_id);
    end
  end

  assign s0_rvalid = pipe_rd[READ_LATENCY-1] && !pipe_id[READ_LATENCY-1] && !rst;
  assign s1_rvalid = pipe_rd[READ_LATENCY-1] &&  pipe_id[READ_LATENCY-1] && !rst;
  assign s0_rdata  = s0_rvalid ? m_dout : rdata0_q;
  assign s1_rdata  = s1_rvalid ? m_dout : rdata1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (s0_rvalid) rdata0_q <= m_dout;
      if (s1_rvalid) rdata1_q <= m_dout;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM environment model, table vectors, directed corner
// sequences and a randomized run against a transaction-level scoreboard.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
  localparam int AW = 12, DW = 32, RL = 2, SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic s0_valid, s0_ready, s0_rvalid, s1_valid, s1_ready, s1_rvalid, m_en;
  logic [AW-1:0] s0_addr, s1_addr, m_addr;
  logic [DW-1:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata, m_din, m_dout;
  logic [SW-1:0] s0_we, s1_we, m_we;
`ifdef BRAM_ARB_LOCK_EN
  logic s0_lock = 1'b0, s1_lock = 1'b0;
`endif
  bit lk0 = 1'b0, lk1 = 1'b0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_we(s0_we), .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_we(s1_we), .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata),
`ifdef BRAM_ARB_LOCK_EN
    .s0_lock(s0_lock), .s1_lock(s1_lock),
`endif
    .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout), .m_en(m_en), .m_we(m_we)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 'h010) return 32'hDEADBEEF;
    if (i == 'h030) return 32'h11223344;
    return {16'(i), 16'(~i)};
  endfunction

  // Read-first BRAM port with READ_LATENCY output registers
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q [RL];
  int edges = 0;
  always @(posedge clk) begin
    edges <= edges + 1;
    if (edges == 0) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
    end else if (m_en) begin
      ram_q[0] <= ram[m_addr];
      for (int b = 0; b < SW; b++)
        if (m_we[b]) ram[m_addr][8*b +: 8] <= m_din[8*b +: 8];
    end
    for (int i = 1; i < RL; i++) ram_q[i] <= ram_q[i-1];
  end
  assign m_dout = ram_q[RL-1];

  // Reference: shadow memory updated in accept order, queue of due responses
  typedef struct { int due; logic id; logic [DW-1:0] data; } rsp_t;
  rsp_t rq[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] last_d [2];
  int t = 0;
  bit mrr = 1'b0;
  bit iss_v = 1'b0;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic [SW-1:0] e_we;
  int n_vec = 0, n_err = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %h expected %h", nm, t, act, exp);
    end
  endtask

  task automatic tick(input logic r,
                      input logic v0, input logic [AW-1:0] a0, input logic [SW-1:0] w0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [SW-1:0] w1, input logic [DW-1:0] d1,
                      input bit use_tab, input logic [1:0] tab_rdy);
    logic [1:0] g;
    logic e0, e1, id;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic [SW-1:0] cw;
    @(negedge clk);
    rst = r;
    s0_valid = v0; s0_addr = a0; s0_we = w0; s0_wdata = d0;
    s1_valid = v1; s1_addr = a1; s1_we = w1; s1_wdata = d1;
`ifdef BRAM_ARB_LOCK_EN
    s0_lock = lk0; s1_lock = lk1;
`endif
    #1;
    if (use_tab)       g = tab_rdy;
    else if (r)        g = 2'b00;
    else if (v0 && v1) g = mrr ? 2'b10 : 2'b01;
    else               g = {v1, v0};
    cmp("ready", {s1_ready, s0_ready}, g);
    e0 = 1'b0; e1 = 1'b0;
    if (!r && rq.size() > 0 && rq[0].due == t) begin
      e0 = !rq[0].id;
      e1 = rq[0].id;
    end
    cmp("rvalid", {s1_rvalid, s0_rvalid}, {e1, e0});
    if (!r) begin
      if (e0 || e1) last_d[rq[0].id] = rq[0].data;
      cmp("s0_rdata", s0_rdata, last_d[0]);
      cmp("s1_rdata", s1_rdata, last_d[1]);
      cmp("m_en", m_en, iss_v);
      cmp("m_we", m_we, iss_v ? e_we : '0);
      cmp("m_addr", m_addr, e_addr);
      cmp("m_din", m_din, e_din);
    end
    if (rq.size() > 0 && rq[0].due <= t) void'(rq.pop_front());
    if (r) begin
      rq.delete();
      mrr = 1'b0; iss_v = 1'b0;
      e_addr = '0; e_din = '0; e_we = '0;
      last_d[0] = '0; last_d[1] = '0;
    end else begin
      iss_v = (g != 2'b00);
      if (g != 2'b00) begin
        id = g[1];
        ca = id ? a1 : a0;
        cd = id ? d1 : d0;
        cw = id ? w1 : w0;
        e_addr = ca; e_din = cd; e_we = cw;
        if (cw == '0) rq.push_back('{due: t + 1 + RL, id: id, data: shadow[ca]});
        else for (int b = 0; b < SW; b++) if (cw[b]) shadow[ca][8*b +: 8] = cd[8*b +: 8];
        mrr = !id;
      end
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, '0, '0, 0, '0, '0, '0, 0, 2'b00);
  endtask
  task automatic do_rst(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, '0, '0, '0, 0, '0, '0, '0, 0, 2'b00);
  endtask
  task automatic go0(input logic [AW-1:0] a, input logic [SW-1:0] w, input logic [DW-1:0] d);
    tick(0, 1, a, w, d, 0, '0, '0, '0, 0, 2'b00);
  endtask
  task automatic go1(input logic [AW-1:0] a, input logic [SW-1:0] w, input logic [DW-1:0] d);
    tick(0, 0, '0, '0, '0, 1, a, w, d, 0, 2'b00);
  endtask

  typedef struct { logic v0; logic v1; logic [1:0] rdy; } vec_t;
  vec_t tab [12];

  initial begin
    logic rv0, rv1, rr_in;
    logic [AW-1:0] ra0, ra1;
    logic [SW-1:0] rw0, rw1;

    tab[0]  = '{1, 1, 2'b01}; tab[1]  = '{1, 1, 2'b10}; tab[2]  = '{1, 1, 2'b01};
    tab[3]  = '{1, 1, 2'b10}; tab[4]  = '{1, 1, 2'b01}; tab[5]  = '{1, 1, 2'b10};
    tab[6]  = '{0, 1, 2'b10}; tab[7]  = '{0, 0, 2'b00}; tab[8]  = '{1, 1, 2'b01};
    tab[9]  = '{1, 0, 2'b01}; tab[10] = '{1, 1, 2'b10}; tab[11] = '{0, 0, 2'b00};

    for (int i = 0; i < (1 << AW); i++) shadow[i] = init_word(i);
    last_d[0] = '0; last_d[1] = '0;
    e_addr = '0; e_din = '0; e_we = '0;
    rst = 1'b1;
    s0_valid = 0; s1_valid = 0;

    do_rst(2);
    go0(12'h010, '0, '0);
    idle(3);
    cmp("rd_010_data", s0_rdata, 32'hDEADBEEF);

    do_rst(1);
    for (int i = 0; i < 12; i++)
      tick(0, tab[i].v0, AW'(12'h040 + i), '0, '0, tab[i].v1, AW'(12'h080 + i), '0, '0, 1, tab[i].rdy);
    idle(4);

    go1(12'h020, 4'hF, 32'hA5A5A5A5);
    go0(12'h020, '0, '0);
    idle(3);
    cmp("wr_rd_020", s0_rdata, 32'hA5A5A5A5);

    go0(12'h030, 4'h2, 32'h0000AB00);
    go0(12'h030, '0, '0);
    idle(3);
    cmp("byte_wr_030", s0_rdata, 32'h1122AB44);

    go1(12'h001, '0, '0);
    go1(12'h002, '0, '0);
    tick(1, 0, '0, '0, '0, 1, 12'h003, '0, '0, 0, 2'b00);
    idle(1);
    cmp("rst_m_en", m_en, 1'b0);
    cmp("rst_m_addr", m_addr, '0);
    cmp("rst_rdata", {s1_rdata, s0_rdata}, '0);
    idle(4);

    go0(12'h005, '0, '0);
    do_rst(1);
    tick(0, 1, 12'h006, '0, '0, 1, 12'h007, '0, '0, 0, 2'b00);
    cmp("rr_after_rst", {s1_ready, s0_ready}, 2'b01);
    idle(4);

`ifdef BRAM_ARB_LOCK_EN
    do_rst(1);
    lk0 = 1'b1;
    for (int i = 0; i < 3; i++)
      tick(0, 1, AW'(12'h100 + i), '0, '0, 1, 12'h200, '0, '0, 1, 2'b01);
    lk0 = 1'b0;
    tick(0, 1, 12'h103, '0, '0, 1, 12'h200, '0, '0, 1, 2'b01);
    tick(0, 1, 12'h104, '0, '0, 1, 12'h200, '0, '0, 1, 2'b10);
    idle(4);
`endif

    do_rst(1);
    for (int i = 0; i < 3000; i++) begin
      rr_in = ($urandom_range(0, 199) == 0);
      rv0 = ($urandom_range(0, 3) != 0);
      rv1 = ($urandom_range(0, 3) != 0);
      ra0 = AW'($urandom_range(0, 15));
      ra1 = AW'($urandom_range(0, 15));
      rw0 = $urandom_range(0, 1) ? '0 : SW'($urandom_range(0, 15));
      rw1 = $urandom_range(0, 1) ? '0 : SW'($urandom_range(0, 15));
      tick(rr_in, rv0, ra0, rw0, DW'($urandom), rv1, ra1, rw1, DW'($urandom), 0, 2'b00);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
